// File: rtl/seed_mode_ctrl_pkg.sv
// seed_mode_pkg: shared types and constants for the seed/mode controller.
// Provides the per-mode action encoding, the mode-to-action mapping, the
// mode-index width helper and the default LFSR tap mask.
package seed_mode_pkg;

    // What the seed register does while a given mode is active.
    typedef enum logic [1:0] {
        ACT_IDLE,
        ACT_HOLD,
        ACT_STEP,
        ACT_RUN
    } action_t;

    // Default feedback taps for a 64-bit register (bits 63, 62, 60, 59).
    localparam logic [63:0] DEFAULT_TAPS = 64'hD800_0000_0000_0000;

    // Modes 0..2 have dedicated actions; every higher mode free-runs.
    function automatic action_t mode_to_action(input int unsigned mode_v);
        action_t act;
        case (mode_v)
            0:       act = ACT_IDLE;
            1:       act = ACT_HOLD;
            2:       act = ACT_STEP;
            default: act = ACT_RUN;
        endcase
        return act;
    endfunction

    // Bits needed to carry a mode index in 0..nsw.
    function automatic int mode_width(input int nsw);
        return (nsw < 1) ? 1 : $clog2(nsw + 1);
    endfunction

endpackage

// File: rtl/seed_mode_ctrl_if.sv
// seed_mode_ctrl_if: switch/seed/step inputs and mode/seed outputs of the
// seed mode controller, bundled for connection between the controller
// (slave side) and whatever drives it (master side).
interface seed_mode_ctrl_if #(
    parameter int WIDTH = 64,
    parameter int NSW   = 3
);
    localparam int MW = seed_mode_pkg::mode_width(NSW);

    logic [NSW-1:0]   sw;
    logic [WIDTH-1:0] seed;
    logic             load;
    logic             step;
    logic [MW-1:0]    mode;
    logic [NSW:0]     mode_oh;
    logic [WIDTH-1:0] shift_seed;
    logic             tick;

    modport master (
        output sw, seed, load, step,
        input  mode, mode_oh, shift_seed, tick
    );

    modport slave (
        input  sw, seed, load, step,
        output mode, mode_oh, shift_seed, tick
    );
endinterface

// File: rtl/seed_mode_ctrl_switch_debounce.sv
// switch_debounce: one user switch, synchronised by a single flop and then
// filtered so that a new level is accepted only after DB_CYCLES consecutive
// synced samples disagree with the accepted level. Any agreeing sample
// restarts the count, so short glitches never reach the output.
// Build option: SEED_MODE_CTRL_DEBOUNCE_EN enables the counter; without it
// the synced level is passed straight through and DB_CYCLES is ignored.
module switch_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_i,
    output logic sw_db_o
);

    logic sync_q;

    // Bring the raw switch level into the clock domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 1'b0;
        end else begin
            sync_q <= sw_i;
        end
    end

`ifdef SEED_MODE_CTRL_DEBOUNCE_EN
    // Counter only needs to reach DB_CYCLES-1; the next differing sample
    // is the one that commits the change.
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic          db_q;

    // Count consecutive disagreeing samples and commit on the last one.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else if (sync_q == db_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            db_q  <= sync_q;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign sw_db_o = db_q;
`else
    assign sw_db_o = sync_q;
`endif

endmodule

// File: rtl/seed_mode_ctrl.sv
// seed_mode_ctrl: debounces NSW switches, priority-encodes them into a mode
// (lowest set switch wins, none set = idle) and drives a Fibonacci LFSR
// seed register that holds, single-steps on step rising edges, or
// free-runs according to the mode. Leaving idle reloads the seed; a zero
// seed is replaced by 1 so the register can never lock up.
// Build option: SEED_MODE_CTRL_DEBOUNCE_EN (see switch_debounce).
module seed_mode_ctrl
    import seed_mode_pkg::*;
#(
    parameter int               WIDTH     = 64,
    parameter int               NSW       = 3,
    parameter int               DB_CYCLES = 4,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(DEFAULT_TAPS)
) (
    input  logic           clk,
    input  logic           reset,
    seed_mode_ctrl_if.slave bus
);

    localparam int               MW       = mode_width(NSW);
    localparam logic [NSW:0]     OH_ONE   = {{NSW{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] SEED_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [NSW-1:0]   sw_db;
    logic [MW-1:0]    mode_d;
    logic [MW-1:0]    mode_q;
    logic [NSW:0]     mode_oh_q;
    logic             entry_q;
    logic             step_q;
    logic             step_prev_q;
    logic             step_rise;
    action_t          act;
    logic             load_evt;
    logic             advance;
    logic [WIDTH-1:0] lfsr_d;
    logic [WIDTH-1:0] lfsr_q;
    logic             tick_d;
    logic             tick_q;

    // One synchroniser/debouncer per switch.
    for (genvar gi = 0; gi < NSW; gi++) begin : g_sw
        switch_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk     (clk),
            .reset   (reset),
            .sw_i    (bus.sw[gi]),
            .sw_db_o (sw_db[gi])
        );
    end

    // Priority encoder: scan high to low so the lowest set switch wins.
    always_comb begin
        mode_d = '0;
        for (int i = NSW - 1; i >= 0; i--) begin
            if (sw_db[i]) begin
                mode_d = MW'(i + 1);
            end
        end
    end

    // Mode register, its one-hot copy, and a flag marking the cycle right
    // after the mode left idle (that cycle performs the entry reload).
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q    <= '0;
            mode_oh_q <= OH_ONE;
            entry_q   <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            mode_oh_q <= OH_ONE << mode_d;
            entry_q   <= (mode_q == '0) && (mode_d != '0);
        end
    end

    // Two-deep step history; a rising edge is only acted on if the mode is
    // STEP when it is seen, otherwise it is simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_q      <= 1'b0;
            step_prev_q <= 1'b0;
        end else begin
            step_q      <= bus.step;
            step_prev_q <= step_q;
        end
    end

    assign step_rise = step_q & ~step_prev_q;
    assign act       = mode_to_action(32'(mode_q));
    assign load_evt  = bus.load | entry_q;
    assign advance   = (act == ACT_RUN) || ((act == ACT_STEP) && step_rise);

    // Next seed value: load beats advance, advance beats hold.
    always_comb begin
        lfsr_d = lfsr_q;
        tick_d = 1'b0;
        if (load_evt) begin
            lfsr_d = (bus.seed == '0) ? SEED_ONE : bus.seed;
        end else if (advance) begin
            lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
            tick_d = 1'b1;
        end
    end

    // Seed register and the advance strobe that accompanies each new value.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= '0;
            tick_q <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            tick_q <= tick_d;
        end
    end

    assign bus.mode       = mode_q;
    assign bus.mode_oh    = mode_oh_q;
    assign bus.shift_seed = lfsr_q;
    assign bus.tick       = tick_q;

endmodule

// File: tb/tb_seed_mode_ctrl.sv
// tb_seed_mode_ctrl: directed scenarios plus a randomized run of the seed
// mode controller (WIDTH=8, NSW=3, DB_CYCLES=4, TAPS=8'hB8), compared
// against a cycle-level behavioural model of the switch/seed rules.
module tb_seed_mode_ctrl;

    localparam int         W   = 8;
    localparam int         NSW = 3;
    localparam int         DB  = 4;
    localparam logic [7:0] TP  = 8'hB8;
`ifdef SEED_MODE_CTRL_DEBOUNCE_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif
    // Edges from the sync capture of a switch change to the new mode.
    localparam int LAT = DB_EN ? DB + 1 : 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seed_mode_ctrl_if #(.WIDTH(W), .NSW(NSW)) bus ();

    seed_mode_ctrl #(
        .WIDTH     (W),
        .NSW       (NSW),
        .DB_CYCLES (DB),
        .TAPS      (TP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- behavioural model ----------------
    logic [2:0] m_sync      = '0;  // level the sync flop holds
    logic [2:0] m_db        = '0;  // accepted switch levels
    logic [2:0] samp_q[$];         // synced samples seen since reset
    int         m_mode      = 0;
    int         m_mode_prev = 0;   // mode before the previous edge
    logic [7:0] m_lfsr      = '0;
    logic       m_tick      = 1'b0;
    logic       m_step_now  = 1'b0; // step sampled at the last edge
    logic       m_step_old  = 1'b0; // step sampled one edge earlier

    function automatic logic [7:0] adv(input logic [7:0] x);
        int n;
        n = $countones(x & TP);
        return {x[6:0], n[0]};
    endfunction

    function automatic int lowest_mode(input logic [2:0] v);
        for (int i = 0; i < 3; i++) begin
            if (v[i]) return i + 1;
        end
        return 0;
    endfunction

    task automatic model_edge();
        logic [2:0] db_next;
        logic [2:0] db_view;
        logic       rise;
        logic       ld;
        int         mode_next;
        if (reset) begin
            m_sync = '0; m_db = '0; samp_q.delete();
            m_mode = 0; m_mode_prev = 0; m_lfsr = '0; m_tick = 1'b0;
            m_step_now = 1'b0; m_step_old = 1'b0;
            return;
        end
        db_next = m_db;
        if (DB_EN) begin
            samp_q.push_back(m_sync);
            if (samp_q.size() > DB) void'(samp_q.pop_front());
            if (samp_q.size() == DB) begin
                for (int b = 0; b < 3; b++) begin
                    bit all_diff;
                    all_diff = 1'b1;
                    foreach (samp_q[k]) if (samp_q[k][b] == m_db[b]) all_diff = 1'b0;
                    if (all_diff) db_next[b] = ~m_db[b];
                end
            end
            db_view = m_db;
        end else begin
            db_view = m_sync;
        end
        mode_next = lowest_mode(db_view);
        rise = m_step_now && !m_step_old;
        ld   = bus.load || (m_mode != 0 && m_mode_prev == 0);
        m_tick = 1'b0;
        if (ld) begin
            m_lfsr = (bus.seed == 8'h00) ? 8'h01 : bus.seed;
        end else if (m_mode >= 3 || (m_mode == 2 && rise)) begin
            m_lfsr = adv(m_lfsr);
            m_tick = 1'b1;
        end
        m_mode_prev = m_mode;
        m_mode      = mode_next;
        m_db        = db_next;
        m_sync      = bus.sw;
        m_step_old  = m_step_now;
        m_step_now  = bus.step;
    endtask

    // One clock: update the model at the edge, return 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic go_idle();
        bus.sw = 3'b000;
        repeat (LAT + 3) cycle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; bus.sw = '0; bus.seed = '0; bus.load = 1'b0; bus.step = 1'b0;
        repeat (2) cycle();
        reset = 1'b0;
        repeat (10) cycle();
        checks++;
        if (bus.mode !== 2'd0) begin failures++; $display("FAIL reset_mode got=%0d exp=0", bus.mode); end
        checks++;
        if (bus.mode_oh !== 4'b0001) begin failures++; $display("FAIL reset_mode_oh got=%b exp=0001", bus.mode_oh); end
        checks++;
        if (bus.shift_seed !== 8'h00) begin failures++; $display("FAIL reset_seed got=%h exp=00", bus.shift_seed); end
        checks++;
        if (bus.tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", bus.tick); end
    endtask

    task automatic test_load_run();
        bus.seed = 8'h80; bus.sw = 3'b100;
        cycle();                       // edge E
        repeat (LAT - 1) cycle();
        checks++;
        if (bus.mode !== 2'd0) begin failures++; $display("FAIL run_mode_early got=%0d exp=0", bus.mode); end
        cycle();                       // E+LAT
        checks++;
        if (bus.mode !== 2'd3 || bus.mode_oh !== 4'b1000) begin
            failures++; $display("FAIL run_mode got=%0d/%b exp=3/1000", bus.mode, bus.mode_oh);
        end
        cycle();
        checks++;
        if (bus.shift_seed !== 8'h80 || bus.tick !== 1'b0) begin
            failures++; $display("FAIL run_load got=%h/%b exp=80/0", bus.shift_seed, bus.tick);
        end
        cycle();
        checks++;
        if (bus.shift_seed !== 8'h01 || bus.tick !== 1'b1) begin
            failures++; $display("FAIL run_adv1 got=%h/%b exp=01/1", bus.shift_seed, bus.tick);
        end
        cycle();
        checks++;
        if (bus.shift_seed !== 8'h02 || bus.tick !== 1'b1) begin
            failures++; $display("FAIL run_adv2 got=%h/%b exp=02/1", bus.shift_seed, bus.tick);
        end
        go_idle();
        checks++;
        if (bus.mode !== 2'd0) begin failures++; $display("FAIL run_exit got=%0d exp=0", bus.mode); end
    endtask

    task automatic test_glitch();
        int max_mode;
        int exp_max;
        max_mode = 0;
        exp_max  = DB_EN ? 0 : 1;
        bus.seed = 8'h3C;
        bus.sw = 3'b001;
        repeat (3) begin cycle(); if (int'(bus.mode) > max_mode) max_mode = int'(bus.mode); end
        bus.sw = 3'b000;
        repeat (LAT + 3) begin cycle(); if (int'(bus.mode) > max_mode) max_mode = int'(bus.mode); end
        checks++;
        if (max_mode !== exp_max) begin failures++; $display("FAIL glitch_mode got=%0d exp=%0d", max_mode, exp_max); end
        bus.sw = 3'b001;
        repeat (LAT + 2) cycle();
        checks++;
        if (bus.mode !== 2'd1 || bus.shift_seed !== 8'h3C || bus.tick !== 1'b0) begin
            failures++; $display("FAIL glitch_hold got=%0d/%h/%b exp=1/3c/0", bus.mode, bus.shift_seed, bus.tick);
        end
    endtask

    task automatic test_priority_zero();
        go_idle();
        bus.seed = 8'h00; bus.sw = 3'b011;
        repeat (LAT + 1) cycle();      // edges E..E+LAT
        checks++;
        if (bus.mode !== 2'd1) begin failures++; $display("FAIL prio_mode got=%0d exp=1", bus.mode); end
        cycle();
        checks++;
        if (bus.shift_seed !== 8'h01) begin failures++; $display("FAIL zero_seed got=%h exp=01", bus.shift_seed); end
        bus.seed = 8'hE7; bus.sw = 3'b010;
        repeat (LAT + 3) cycle();
        checks++;
        if (bus.mode !== 2'd2 || bus.shift_seed !== 8'h01) begin
            failures++; $display("FAIL no_reload got=%0d/%h exp=2/01", bus.mode, bus.shift_seed);
        end
    endtask

    task automatic test_step();
        int ticks;
        bus.seed = 8'h80; bus.load = 1'b1;
        cycle();
        bus.load = 1'b0;
        checks++;
        if (bus.shift_seed !== 8'h80 || bus.tick !== 1'b0) begin
            failures++; $display("FAIL step_load got=%h/%b exp=80/0", bus.shift_seed, bus.tick);
        end
        ticks = 0;
        bus.step = 1'b1;
        cycle(); ticks += int'(bus.tick);
        bus.step = 1'b0;
        cycle(); ticks += int'(bus.tick);
        checks++;
        if (bus.shift_seed !== 8'h01 || bus.tick !== 1'b1) begin
            failures++; $display("FAIL step_first got=%h/%b exp=01/1", bus.shift_seed, bus.tick);
        end
        cycle(); ticks += int'(bus.tick);
        checks++;
        if (bus.tick !== 1'b0) begin failures++; $display("FAIL step_pulse_width got=%b exp=0", bus.tick); end
        bus.step = 1'b1;               // second pulse, then held high
        repeat (8) begin cycle(); ticks += int'(bus.tick); end
        checks++;
        if (bus.shift_seed !== 8'h02) begin failures++; $display("FAIL step_second got=%h exp=02", bus.shift_seed); end
        bus.step = 1'b0;
        repeat (2) begin cycle(); ticks += int'(bus.tick); end
        checks++;
        if (ticks !== 2) begin failures++; $display("FAIL step_ticks got=%0d exp=2", ticks); end
    endtask

    task automatic test_mid_run();
        bus.sw = 3'b100;
        repeat (LAT + 2) cycle();
        checks++;
        if (bus.mode !== 2'd3 || bus.tick !== 1'b1) begin
            failures++; $display("FAIL midrun_enter got=%0d/%b exp=3/1", bus.mode, bus.tick);
        end
        bus.seed = 8'h5A; bus.load = 1'b1;
        cycle();
        bus.load = 1'b0;
        checks++;
        if (bus.shift_seed !== 8'h5A || bus.tick !== 1'b0) begin
            failures++; $display("FAIL midrun_load got=%h/%b exp=5a/0", bus.shift_seed, bus.tick);
        end
        cycle();
        checks++;
        if (bus.shift_seed !== 8'hB4 || bus.tick !== 1'b1) begin
            failures++; $display("FAIL midrun_adv got=%h/%b exp=b4/1", bus.shift_seed, bus.tick);
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        checks++;
        if (bus.mode !== 2'd0 || bus.mode_oh !== 4'b0001 || bus.shift_seed !== 8'h00 || bus.tick !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset got=%0d/%b/%h/%b exp=0/0001/00/0",
                     bus.mode, bus.mode_oh, bus.shift_seed, bus.tick);
        end
        bus.sw = 3'b000;
        repeat (LAT + 3) cycle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            reset    = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 5) == 0) bus.sw = 3'($urandom);
            bus.load = ($urandom_range(0, 39) == 0);
            bus.seed = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 2) == 0) bus.step = ~bus.step;
            cycle();
            checks++;
            if (bus.mode !== 2'(m_mode) || bus.mode_oh !== 4'(1 << m_mode) ||
                bus.shift_seed !== m_lfsr || bus.tick !== m_tick) begin
                failures++;
                $display("FAIL random cyc=%0d got mode=%0d oh=%b seed=%h tick=%b exp mode=%0d oh=%b seed=%h tick=%b",
                         c, bus.mode, bus.mode_oh, bus.shift_seed, bus.tick,
                         m_mode, 4'(1 << m_mode), m_lfsr, m_tick);
            end
        end
        reset = 1'b0; bus.load = 1'b0; bus.step = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_run();
        test_glitch();
        test_priority_zero();
        test_step();
        test_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seed_mode_ctrl.md
# seed_mode_ctrl

Parametrised mode controller and seed shifter for the pattern/seed path. It debounces NSW user switches and priority-encodes them into a mode. It loads a WIDTH-bit seed on entry from idle and advances it as a Fibonacci LFSR, holding it, single-stepping it or free-running it depending on the mode. It replaces the fixed two-switch, three-state selector and feeds `shift_seed` to the downstream pattern logic.

## Interface
- WIDTH, 64: seed/LFSR width, ≥ 4.
- NSW, 3: number of mode switches, ≥ 1; modes 0..NSW.
- DB_CYCLES, 4: consecutive stable samples required to accept a switch change, ≥ 1.
- TAPS, 64'hD800_0000_0000_0000: feedback tap mask, WIDTH bits.
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- sw  in  NSW  raw switch levels, asynchronous to clk.
- seed  in  WIDTH  seed value, sampled on load events.
- load  in  1  synchronous load request.
- step  in  1  single-step request, level; acted on at rising edges.
- mode  out  $clog2(NSW+1)  current mode index.
- mode_oh  out  NSW+1  one-hot of mode.
- shift_seed  out  WIDTH  LFSR state.
- tick  out  1  high for one cycle after each LFSR advance.

## Operation
- Reset values: mode=0, mode_oh=1, shift_seed=0, tick=0, debounce counters=0, debounced switches=0, step history=0.
- sw passes through one sync flop, then the debouncer, giving sw_db.
- Mode select: mode = 1 + index of the lowest set bit of sw_db; mode = 0 if none is set. The lowest index wins when several switches are set.
- Mode actions:
  - 0 (IDLE): shift_seed holds.
  - 1 (HOLD): shift_seed holds.
  - 2 (STEP): one advance per rising edge of step.
  - ≥3 (RUN): one advance every cycle.
- With NSW < 3 the unreachable actions simply do not exist.
- Advance rule: shift_seed <= {shift_seed[WIDTH-2:0], ^(shift_seed & TAPS)}.
- Load event: load=1, or mode changing from 0 to nonzero. The register takes seed. If seed==0, it takes 1 instead (prevents lock-up).
- Priority: reset > load event > advance > hold. A load event suppresses the advance and tick in the same cycle.
- Mode change from nonzero to 0 leaves shift_seed unchanged. Re-entry from 0 reloads.
- A switch change between nonzero modes does not reload.
- step edges seen while the mode is not STEP are discarded; they are not queued.
- Reset mid-debounce clears the counters; the pending change is lost.

## Timing
- sw changes before edge E (sync capture at E):
  - with debounce: sw_db updates at edge E+DB_CYCLES if the synced value stayed different for DB_CYCLES consecutive edges; mode updates at E+DB_CYCLES+1.
  - without debounce: mode updates at E+1.
- Any synced sample equal to sw_db resets that switch's counter to 0 (glitch rejection).
- Load: load high at edge E → shift_seed=seed from E.
- Entry from idle: the load happens at the edge after mode becomes nonzero.
- Advance visible one cycle after the triggering edge. tick asserts in the same cycle the new value is visible.
- STEP: step rising between edges E-1 and E → advance at E+1. In RUN, tick is continuously high.

## Configuration
- SEED_MODE_CTRL_DEBOUNCE_EN defined: per-switch debounce counters active, with DB_CYCLES semantics as above.
- Not defined: sw_db = synced sw directly. DB_CYCLES is ignored and no counters are instantiated.

## Structure
- Package seed_mode_pkg:
  - enum action_t {ACT_IDLE, ACT_HOLD, ACT_STEP, ACT_RUN}.
  - function mode_to_action(mode) mapping modes ≥3 to ACT_RUN.
  - default TAPS constant.
- Sub-module switch_debounce: one switch, sync flop plus counter, parameter DB_CYCLES. Generated NSW times; its counter body sits under the macro.
- Top holds the mode encoder, the mode register, step edge detection and the LFSR register.

## Test plan
All scenarios use WIDTH=8, TAPS=8'hB8, NSW=3, DB_CYCLES=4, debounce enabled.
- Reset released, sw=0 for 10 cycles → mode=0, mode_oh=4'b0001, shift_seed=8'h00, tick=0.
- Load 0x80 then RUN:
  - seed=8'h80, sw=3'b100 stable → mode=3 at E+5, shift_seed=8'h80 at E+6.
  - Then 8'h01 at E+7 and 8'h02 at E+8, with tick=1 from E+7.
- Glitch rejection: sw=3'b001 for 3 cycles then back to 0 → mode stays 0. Holding it for 4+ cycles → mode=1 and shift_seed=seed.
- Priority and zero seed:
  - sw=3'b011 → mode=1.
  - seed=0 on entry → shift_seed=8'h01.
- STEP mode, shift_seed=8'h80, step pulsed twice (3 cycles apart) → 8'h01, then 8'h02. Exactly two single-cycle tick pulses; holding step high gives no further advance.
- Controls mid-run: in RUN, load=1 with seed=8'h5A → shift_seed=8'h5A, no tick that cycle. Then reset=1 for one cycle → all outputs return to their reset values on the next edge.
